// File: rtl/spi_memory_pkg.sv
// Shared definitions for the SPI memory control FSM: state encoding, output bundle
// and the state-to-output decode used by the registered output stage.
package spi_memory_pkg;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic RW_READ       = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        ADDR_WAIT,
        ADDR_LATCH,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_WAIT,
        WRITE_MEM,
        DONE
    } state_e;

    typedef struct packed {
        logic address_latch_enable;
        logic parallel_load;
        logic data_mem_write_enable;
        logic miso_buffer_enable;
    } fsm_out_t;

    function automatic fsm_out_t decode_outputs(input state_e s);
        fsm_out_t o;
        o = '0;
        case (s)
            ADDR_LATCH: o.address_latch_enable  = 1'b1;
            READ_LOAD:  o.parallel_load         = 1'b1;
            WRITE_MEM:  o.data_mem_write_enable = 1'b1;
            READ_SHIFT: o.miso_buffer_enable    = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

    // States in which SCLK rising-edge strobes advance the bit counter.
    function automatic logic counts_sclk(input state_e s);
        return (s == GET_ADDR) || (s == READ_SHIFT) || (s == WRITE_SHIFT);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating strobe counter with synchronous clear; terminal_o flags the increment
// that brings the count up to width.
module spi_bit_counter #(
    parameter int width = 8,
    parameter int cnt_w = $clog2(width + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [cnt_w-1:0] count_o,
    output logic             terminal_o
);

    logic [cnt_w-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default assignment first so every path drives count_d; a missing branch would infer a latch.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register updates from values sampled before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = inc_i && (count_q == cnt_w'(width - 1));

endmodule

// File: rtl/spi_memory_fsm.sv
// Transaction sequencer for the SPI memory peripheral: address + R/W field, then a
// data field, driving address latch, parallel load, memory write and MISO enable.
module spi_memory_fsm
    import spi_memory_pkg::*;
#(
    parameter int width          = DEFAULT_WIDTH,
    parameter int memReadLatency = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic chipSelect,
    input  logic peripheralClkPosEdge,
    input  logic peripheralClkNegEdge,
    input  logic readWriteBit,
    output logic parallelLoad,
    output logic addressLatchEnable,
    output logic dataMemWriteEnable,
    output logic misoBufferEnable
);

    localparam int CNT_MAX = (width > memReadLatency) ? width : memReadLatency;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    fsm_out_t         out_q, out_d;
    logic [CNT_W-1:0] bit_count;
    logic             field_done;
    logic             count_clear;
    logic             count_inc;

    // READ_WAIT reuses the counter as a clk-cycle timer for the memory read latency.
    assign count_inc   = (counts_sclk(state_q) && peripheralClkPosEdge) || (state_q == READ_WAIT);
    assign count_clear = (state_d != state_q);

    spi_bit_counter #(
        .width (width),
        .cnt_w (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (count_clear),
        .inc_i      (count_inc),
        .count_o    (bit_count),
        .terminal_o (field_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (!chipSelect) state_d = GET_ADDR;
            GET_ADDR:    if (field_done) state_d = ADDR_WAIT;
            ADDR_WAIT:   state_d = ADDR_LATCH;
            ADDR_LATCH:  state_d = (readWriteBit == RW_READ) ? READ_WAIT : WRITE_SHIFT;
            READ_WAIT:   if (bit_count == CNT_W'(memReadLatency - 1)) state_d = READ_LOAD;
            READ_LOAD:   state_d = READ_SHIFT;
            // Hold the last bit on MISO through the final SCLK high phase; a coincident posedge wins.
            READ_SHIFT:  if ((bit_count == CNT_W'(width)) && peripheralClkNegEdge
                             && !peripheralClkPosEdge) state_d = DONE;
            WRITE_SHIFT: if (field_done) state_d = WRITE_WAIT;
            WRITE_WAIT:  state_d = WRITE_MEM;
            WRITE_MEM:   state_d = DONE;
            DONE:        state_d = DONE;
            default:     state_d = IDLE;
        endcase
        if ((state_q != IDLE) && chipSelect) begin
            state_d = IDLE;
        end
    end

    // Decoding the next state lets the registered outputs change on the edge that enters a state.
    always_comb begin
        out_d = decode_outputs(state_d);
    end

    assign addressLatchEnable = out_q.address_latch_enable;
    assign parallelLoad       = out_q.parallel_load;
    assign dataMemWriteEnable = out_q.data_mem_write_enable;
    assign misoBufferEnable   = out_q.miso_buffer_enable;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Scoreboard bench for spi_memory_fsm: stimulus queues expected output edges with their
// clk cycle, an independent monitor pops and compares every observed output edge.
module tb_spi_memory_fsm;

    localparam int LAT = 1;

    typedef struct packed {
        logic [1:0]  sig;
        logic        lvl;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic chipSelect;
    logic pos_strobe;
    logic neg_strobe;
    logic readWriteBit;
    logic parallelLoad;
    logic addressLatchEnable;
    logic dataMemWriteEnable;
    logic misoBufferEnable;

    logic       mosi;
    logic [7:0] sr;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    ev_t        exp_q[$];
    logic [3:0] prev = '0;
    logic [3:0] cur;
    string      sig_name[4] = '{"addressLatchEnable", "parallelLoad", "dataMemWriteEnable", "misoBufferEnable"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream shift register: parallel output bit 0 lags its contents by one clk.
    always @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            readWriteBit <= 1'b0;
        end else begin
            if (pos_strobe) sr <= {sr[6:0], mosi};
            readWriteBit <= sr[0];
        end
    end

    spi_memory_fsm dut (
        .clk                  (clk),
        .reset                (reset),
        .chipSelect           (chipSelect),
        .peripheralClkPosEdge (pos_strobe),
        .peripheralClkNegEdge (neg_strobe),
        .readWriteBit         (readWriteBit),
        .parallelLoad         (parallelLoad),
        .addressLatchEnable   (addressLatchEnable),
        .dataMemWriteEnable   (dataMemWriteEnable),
        .misoBufferEnable     (misoBufferEnable)
    );

    assign cur = {misoBufferEnable, dataMemWriteEnable, parallelLoad, addressLatchEnable};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic l, input int c);
        ev_t e;
        e.sig = s[1:0];
        e.lvl = l;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge on any output is an event that must match the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (cur[i] !== prev[i]) begin
                ev_t got;
                ev_t want;
                got.sig = 2'(i);
                got.lvl = cur[i];
                got.cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_edge %s: level %b at cycle %0d, none expected",
                             sig_name[i], cur[i], cyc);
                end else begin
                    want = exp_q.pop_front();
                    check({sig_name[i], " edge{sig,lvl,cyc}"}, {29'd0, got}, {29'd0, want});
                end
            end
        end
        prev = cur;
    end

    task automatic strobe(input bit is_pos, input logic d, output int c);
        @(posedge clk);
        #1;
        if (is_pos) begin
            pos_strobe = 1'b1;
            mosi       = d;
        end else begin
            neg_strobe = 1'b1;
        end
        c = cyc;
        @(posedge clk);
        #1;
        pos_strobe = 1'b0;
        neg_strobe = 1'b0;
    endtask

    // One CS-low window: n_bits SCLK periods of {cmd, data}; CS raised for cs_hi clks after (0 = leave low).
    task automatic xfer(input logic [7:0] cmd, input logic [15:0] data, input int n_bits, input int cs_hi);
        logic [23:0] stream;
        int pc;
        int nc;
        stream     = {cmd, data};
        chipSelect = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < n_bits; i++) begin
            strobe(1'b1, (i < 24) ? stream[23 - i] : 1'b0, pc);
            if (i == 7) begin
                push(0, 1'b1, pc + 2);
                push(0, 1'b0, pc + 3);
                if (cmd[0]) begin
                    push(1, 1'b1, pc + 3 + LAT);
                    push(1, 1'b0, pc + 4 + LAT);
                    push(3, 1'b1, pc + 4 + LAT);
                end
            end
            if ((i == 15) && !cmd[0]) begin
                push(2, 1'b1, pc + 2);
                push(2, 1'b0, pc + 3);
            end
            repeat (2) @(posedge clk);
            strobe(1'b0, 1'b0, nc);
            if ((i == 15) && cmd[0]) push(3, 1'b0, nc + 1);
            repeat (2) @(posedge clk);
        end
        if (cs_hi > 0) begin
            repeat (3) @(posedge clk);
            #1;
            chipSelect = 1'b1;
            repeat (cs_hi) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int pc;
        int nc;
        reset      = 1'b1;
        chipSelect = 1'b1;
        pos_strobe = 1'b0;
        neg_strobe = 1'b0;
        mosi       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_addressLatchEnable", 64'(addressLatchEnable), 64'd0);
        check("reset_parallelLoad",       64'(parallelLoad),       64'd0);
        check("reset_dataMemWriteEnable", 64'(dataMemWriteEnable), 64'd0);
        check("reset_misoBufferEnable",   64'(misoBufferEnable),   64'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        xfer(8'h54, 16'hC300, 16, 4);   // write addr 0x2A, data 0xC3
        xfer(8'h55, 16'h0000, 16, 4);   // read addr 0x2A
        xfer(8'h54, 16'hC300, 12, 4);   // aborted write: CS high after 12 posedges
        xfer(8'h02, 16'hFF00, 16, 4);   // write addr 0x01, data 0xFF
        xfer(8'h54, 16'hC3AA, 24, 4);   // overrun: 24 posedges, one write only
        xfer(8'h55, 16'h0000, 16, 1);   // back-to-back reads, CS high 1 clk
        xfer(8'h55, 16'h0000, 16, 4);

        // Async reset in the middle of the read data phase.
        xfer(8'h55, 16'h0000, 11, 0);
        @(posedge clk);
        #2;
        push(3, 1'b0, cyc);
        reset = 1'b1;
        #1;
        check("async_reset_misoBufferEnable",   64'(misoBufferEnable),   64'd0);
        check("async_reset_parallelLoad",       64'(parallelLoad),       64'd0);
        check("async_reset_addressLatchEnable", 64'(addressLatchEnable), 64'd0);
        check("async_reset_dataMemWriteEnable", 64'(dataMemWriteEnable), 64'd0);
        chipSelect = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            strobe(1'b1, 1'b1, pc);
            strobe(1'b0, 1'b0, nc);
        end
        xfer(8'h54, 16'hC300, 16, 4);

        repeat (20) @(posedge clk);
        check("pending_expected_edges", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d edges still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_memory_fsm.md
Name: spi_memory_fsm

Overview:
Control FSM for the SPI memory peripheral, directly downstream of the SPI shift register. It consumes the conditioned chip-select, the SCLK edge strobes and bit 0 of the shift register's parallel output. It sequences the transaction: 7-bit address + R/W bit, then an 8-bit data phase. It drives the shift register's parallelLoad, the address latch, the data-memory write enable and the MISO tristate enable.

Parameters:
width, 8, bits per SPI field (address+R/W field and data field); counter sized to hold width.
memReadLatency, 1, clk cycles between address latch and valid memory read data.

Ports:
clk  in  1  FPGA clock
reset  in  1  asynchronous, active-high reset
chipSelect  in  1  conditioned CS, active low; high aborts any transaction
peripheralClkPosEdge  in  1  one-clk strobe on SCLK rising edge (same strobe feeding shift register)
peripheralClkNegEdge  in  1  one-clk strobe on SCLK falling edge
readWriteBit  in  1  shift register parallelDataOut[0]; 1 = read, 0 = write
parallelLoad  out  1  to shift register: load from data memory output
addressLatchEnable  out  1  capture shift register parallelDataOut[7:1] as address
dataMemWriteEnable  out  1  write shift register parallelDataOut to memory[address]
misoBufferEnable  out  1  enable MISO output driver

Behaviour:
- Reset (async, active-high): state IDLE, bitCount 0, all outputs 0. Reset mid-transaction aborts it; no write occurs.
- All outputs registered (Moore, decoded from state register); each asserts in the clk cycle state is entered +0 (outputs change on the clk edge that enters the state).
- bitCount: counts peripheralClkPosEdge strobes in counting states; cleared on every state entry.
- States/transitions (chipSelect==1 from any non-IDLE state -> IDLE next clk, overriding all else):
  IDLE: chipSelect==0 -> GET_ADDR.
  GET_ADDR: count posedges; on the strobe making bitCount==width -> ADDR_WAIT.
  ADDR_WAIT: 1 clk (shift register output lags its contents by one clk) -> ADDR_LATCH.
  ADDR_LATCH: addressLatchEnable=1 for exactly 1 clk; sample readWriteBit; 1 -> READ_WAIT, 0 -> WRITE_SHIFT.
  READ_WAIT: memReadLatency clks -> READ_LOAD.
  READ_LOAD: parallelLoad=1 for exactly 1 clk -> READ_SHIFT.
  READ_SHIFT: misoBufferEnable=1; count posedges; after width posedges, stay until next peripheralClkNegEdge (last bit held through final SCLK high) -> DONE.
  WRITE_SHIFT: count posedges; at width -> WRITE_WAIT (1 clk, output lag) -> WRITE_MEM.
  WRITE_MEM: dataMemWriteEnable=1 for exactly 1 clk -> DONE.
  DONE: all outputs 0; wait for chipSelect==1 -> IDLE. Extra SCLK edges ignored.
- Posedge and negedge strobes asserted in the same clk: posedge handled, negedge ignored (cannot occur with a conditioned SCLK).
- Write commits only after all width data bits; CS high before WRITE_MEM means no write.
- No more than one addressLatchEnable, parallelLoad or dataMemWriteEnable pulse per CS-low window.

Decomposition:
- Shared package spi_memory_pkg: state encoding constants (IDLE, GET_ADDR, ADDR_WAIT, ADDR_LATCH, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_WAIT, WRITE_MEM, DONE), RW_READ=1, default field width 8.
- One natural sub-module, spi_bit_counter: posedge-strobe counter with synchronous clear, async reset and terminal-count flag.

Test Plan:
- Reset asserted mid-READ_SHIFT -> all outputs 0 immediately (async), state IDLE; after release, nothing asserts until chipSelect falls.
- Write: CS low, shift 0x54 (addr 0x2A, RW=0), then 0xC3 -> exactly one addressLatchEnable pulse 2 clks after 8th posedge; one dataMemWriteEnable pulse 2 clks after 16th posedge; misoBufferEnable never 1.
- Read: CS low, shift 0x55 (addr 0x2A, RW=1) -> addressLatchEnable pulse, then parallelLoad pulse memReadLatency+1 clks later; misoBufferEnable high for 8 SCLK periods, drops on the negedge after the 16th posedge; dataMemWriteEnable never 1.
- Abort: CS high after 12 SCLK posedges of a write -> IDLE next clk, no dataMemWriteEnable; next transaction (write 0x02, data 0xFF) completes normally.
- Overrun: 24 SCLK posedges in one CS window (write) -> exactly one dataMemWriteEnable pulse; FSM stays in DONE until CS high.
- Back-to-back: CS high for 1 clk between two reads -> two independent address latch and parallelLoad sequences, bitCount restarts at 0.
